// File: rtl/prv664_pkg.sv
// Shared types for the prv664 pipeline.
// Dispatch packet layout, unit indices and small helpers.
package prv664_pkg;

  localparam int DISP_ALU = 0;
  localparam int DISP_BRU = 1;
  localparam int DISP_LSU = 2;
  localparam int DISP_FPU = 3;

  localparam int NREG = 32;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic        rs1en;
    logic [4:0]  rs2;
    logic        rs2en;
    logic [4:0]  frs1;
    logic        frs1en;
    logic [4:0]  frs2;
    logic        frs2en;
    logic [4:0]  frs3;
    logic        frs3en;
    logic [4:0]  rd;
    logic        rden;
    logic [4:0]  frd;
    logic        frden;
    logic [63:0] pc;
    logic [19:0] imm;
    logic [11:0] csrindex;
    logic        csren;
    logic        fflagen;
    logic [7:0]  itag;
  } disp_pkt_t;

  function automatic logic [NREG-1:0] idx2mask(
    input logic [4:0] idx
  );
    logic [NREG-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pip_decode_interface.sv
// Decode-to-dispatch handshake.
// One packet plus its one-hot unit selector.
interface pip_decode_interface
  import prv664_pkg::*;
#(
  parameter int NUNIT = 4
);

  logic             valid;
  logic             ready;
  disp_pkt_t        pkt;
  logic [NUNIT-1:0] disp_dest;

  modport master (
    output valid,
    output pkt,
    output disp_dest,
    input  ready
  );

  modport slave (
    input  valid,
    input  pkt,
    input  disp_dest,
    output ready
  );

endinterface

// File: rtl/pip_scoreboard.sv
// Register busy scoreboard with writeback bypass.
// Reads see busy minus this cycle's clear.
module pip_scoreboard
  import prv664_pkg::*;
#(
  parameter bit ZERO_REG_HARDWIRED = 1'b0,
  parameter int NRD = 3
) (
  input  logic                clk_i,
  input  logic                arst_n,
  input  logic                flush_i,
  input  logic                set_i,
  input  logic [4:0]          set_idx_i,
  input  logic                clr_i,
  input  logic [4:0]          clr_idx_i,
  input  logic [NRD-1:0][4:0] rd_idx_i,
  output logic [NRD-1:0]      rd_busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_eff;

  assign set_mask = set_i ? idx2mask(set_idx_i) : '0;
  assign clr_mask = clr_i ? idx2mask(clr_idx_i) : '0;
  assign busy_eff = busy_q & ~clr_mask;

  // Next busy vector: set beats clear, flush beats all.
  always_comb begin
    busy_d = busy_eff | set_mask;
    if (ZERO_REG_HARDWIRED) begin
      busy_d[0] = 1'b0;
    end
    if (flush_i) begin
      busy_d = '0;
    end
  end

  // Bypassed read ports.
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy_o[k] = busy_eff[rd_idx_i[k]];
    end
  end

  // Busy register.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/pip_disp_stage.sv
// Single-entry dispatch slot after decode.
// Checks int/fp hazards and routes to one unit.
module pip_disp_stage
  import prv664_pkg::*;
#(
  parameter int NUNIT = 4
) (
  input  logic             clk_i,
  input  logic             arst_n,
  input  logic             flush_i,
  pip_decode_interface.slave dec,
  output logic [NUNIT-1:0] unit_valid_o,
  input  logic [NUNIT-1:0] unit_ready_i,
  output disp_pkt_t        unit_pkt_o,
  input  logic             iwb_valid_i,
  input  logic [4:0]       iwb_index_i,
  input  logic             fwb_valid_i,
  input  logic [4:0]       fwb_index_i,
  output logic             stall_o
);

  logic             slot_valid_q;
  logic             slot_valid_d;
  disp_pkt_t        slot_pkt_q;
  disp_pkt_t        slot_pkt_d;
  logic [NUNIT-1:0] slot_dest_q;
  logic [NUNIT-1:0] slot_dest_d;

  logic [NUNIT-1:0] dec_dest_low;
  logic [2:0][4:0]  i_idx;
  logic [2:0]       i_busy;
  logic [3:0][4:0]  f_idx;
  logic [3:0]       f_busy;
  logic             ihaz;
  logic             fhaz;
  logic             hazard;
  logic             dest_nz;
  logic             go;
  logic             fire;
  logic             accept;
  logic             iset;
  logic             fset;

  // Keep only the lowest selector bit of a malformed multi-hot dest.
  assign dec_dest_low =
    dec.disp_dest & (~dec.disp_dest + NUNIT'(1));

  // Scoreboard read indices from the held packet.
  always_comb begin
    i_idx[0] = slot_pkt_q.rs1;
    i_idx[1] = slot_pkt_q.rs2;
    i_idx[2] = slot_pkt_q.rd;
    f_idx[0] = slot_pkt_q.frs1;
    f_idx[1] = slot_pkt_q.frs2;
    f_idx[2] = slot_pkt_q.frs3;
    f_idx[3] = slot_pkt_q.frd;
  end

  assign ihaz = (slot_pkt_q.rs1en & i_busy[0])
              | (slot_pkt_q.rs2en & i_busy[1])
              | (slot_pkt_q.rden  & i_busy[2]);
  assign fhaz = (slot_pkt_q.frs1en & f_busy[0])
              | (slot_pkt_q.frs2en & f_busy[1])
              | (slot_pkt_q.frs3en & f_busy[2])
              | (slot_pkt_q.frden  & f_busy[3]);
  assign hazard  = ihaz | fhaz;
  assign dest_nz = |slot_dest_q;
  assign go      = slot_valid_q & ~hazard & ~flush_i;
  assign fire    = go & (~dest_nz | |(slot_dest_q & unit_ready_i));
  assign accept  = dec.valid & dec.ready;

  assign dec.ready    = ~flush_i & (~slot_valid_q | fire);
  assign unit_valid_o = {NUNIT{go}} & slot_dest_q;
  assign unit_pkt_o   = slot_pkt_q;
  assign stall_o      = slot_valid_q & ~fire & ~flush_i;

  // Zero-dest packets complete without claiming a destination.
  assign iset = fire & slot_pkt_q.rden
              & (slot_pkt_q.rd != 5'd0) & dest_nz;
  assign fset = fire & slot_pkt_q.frden & dest_nz;

  // Slot next state: flush empties, load refills, fire drains.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_pkt_d   = slot_pkt_q;
    slot_dest_d  = slot_dest_q;
    if (flush_i) begin
      slot_valid_d = 1'b0;
    end else if (accept) begin
      slot_valid_d = 1'b1;
      slot_pkt_d   = dec.pkt;
      slot_dest_d  = dec_dest_low;
    end else if (fire) begin
      slot_valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      slot_valid_q <= 1'b0;
      slot_pkt_q   <= '0;
      slot_dest_q  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_pkt_q   <= slot_pkt_d;
      slot_dest_q  <= slot_dest_d;
    end
  end

  pip_scoreboard #(
    .ZERO_REG_HARDWIRED (1'b1),
    .NRD                (3)
  ) u_iscb (
    .clk_i     (clk_i),
    .arst_n    (arst_n),
    .flush_i   (flush_i),
    .set_i     (iset),
    .set_idx_i (slot_pkt_q.rd),
    .clr_i     (iwb_valid_i),
    .clr_idx_i (iwb_index_i),
    .rd_idx_i  (i_idx),
    .rd_busy_o (i_busy)
  );

  pip_scoreboard #(
    .ZERO_REG_HARDWIRED (1'b0),
    .NRD                (4)
  ) u_fscb (
    .clk_i     (clk_i),
    .arst_n    (arst_n),
    .flush_i   (flush_i),
    .set_i     (fset),
    .set_idx_i (slot_pkt_q.frd),
    .clr_i     (fwb_valid_i),
    .clr_idx_i (fwb_index_i),
    .rd_idx_i  (f_idx),
    .rd_busy_o (f_busy)
  );

endmodule

// File: tb/tb_pip_disp_stage.sv
// Bench for pip_disp_stage.
// Cycle vectors, reset sequence, random stream.
module tb_pip_disp_stage;
  import prv664_pkg::*;

  typedef struct packed {
    logic        v;
    logic [7:0]  tag;
    logic [3:0]  dest;
    logic [4:0]  rs1;
    logic        rs1e;
    logic [4:0]  rs2;
    logic        rs2e;
    logic [4:0]  rd;
    logic        rde;
    logic [4:0]  f3;
    logic        f3e;
    logic [4:0]  frd;
    logic        frde;
    logic [3:0]  ur;
    logic        iv;
    logic [4:0]  ii;
    logic        fv;
    logic [4:0]  fi;
    logic        fl;
    logic        erdy;
    logic [3:0]  euv;
    logic        est;
    logic [7:0]  etag;
    logic        cb;
    logic [31:0] ebi;
    logic [31:0] ebf;
  } vec_t;

  typedef struct packed {
    logic [7:0] tag;
    logic [3:0] dest;
  } exp_t;

  logic       clk;
  logic       arst_n;
  logic       flush;
  logic [3:0] uv;
  logic [3:0] ur;
  disp_pkt_t  upkt;
  logic       iwbv;
  logic [4:0] iwbi;
  logic       fwbv;
  logic [4:0] fwbi;
  logic       stall;

  int n_cmp;
  int n_bad;

  vec_t tv[$];
  exp_t exp_q[$];

  pip_decode_interface #(.NUNIT(4)) dec_if ();

  pip_disp_stage #(.NUNIT(4)) dut (
    .clk_i        (clk),
    .arst_n       (arst_n),
    .flush_i      (flush),
    .dec          (dec_if),
    .unit_valid_o (uv),
    .unit_ready_i (ur),
    .unit_pkt_o   (upkt),
    .iwb_valid_i  (iwbv),
    .iwb_index_i  (iwbi),
    .fwb_valid_i  (fwbv),
    .fwb_index_i  (fwbi),
    .stall_o      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v,
                              input logic [7:0] tag,
                              input logic [3:0] dest);
    vec_t t;
    t = '0;
    t.v = v;
    t.tag = tag;
    t.dest = dest;
    t.ur = 4'hF;
    return t;
  endfunction

  function automatic vec_t ex(input vec_t t,
                              input logic r,
                              input logic [3:0] u,
                              input logic s,
                              input logic [7:0] g);
    vec_t o;
    o = t;
    o.erdy = r;
    o.euv = u;
    o.est = s;
    o.etag = g;
    return o;
  endfunction

  task automatic drv(input vec_t t);
    disp_pkt_t p;
    p = '0;
    p.itag = t.tag;
    p.rs1 = t.rs1;
    p.rs1en = t.rs1e;
    p.rs2 = t.rs2;
    p.rs2en = t.rs2e;
    p.rd = t.rd;
    p.rden = t.rde;
    p.frs3 = t.f3;
    p.frs3en = t.f3e;
    p.frd = t.frd;
    p.frden = t.frde;
    p.pc = {56'h0, t.tag};
    dec_if.valid = t.v;
    dec_if.pkt = p;
    dec_if.disp_dest = t.dest;
    ur = t.ur;
    iwbv = t.iv;
    iwbi = t.ii;
    fwbv = t.fv;
    fwbi = t.fi;
    flush = t.fl;
  endtask

  task automatic build();
    vec_t t;
    t = mk(1, 1, 1); tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(1, 2, 1); tv.push_back(ex(t, 1, 1, 0, 1));
    t = mk(1, 3, 1); tv.push_back(ex(t, 1, 1, 0, 2));
    t = mk(0, 0, 0); tv.push_back(ex(t, 1, 1, 0, 3));
    t = mk(0, 0, 0); tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(1, 4, 1); t.rd = 5; t.rde = 1;
    tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(1, 5, 1); t.rs1 = 5; t.rs1e = 1;
    t.rs2 = 7; t.rs2e = 1; t.rd = 6; t.rde = 1;
    tv.push_back(ex(t, 1, 1, 0, 4));
    t = mk(0, 0, 0); tv.push_back(ex(t, 0, 0, 1, 0));
    t = mk(0, 0, 0); tv.push_back(ex(t, 0, 0, 1, 0));
    t = mk(0, 0, 0); t.iv = 1; t.ii = 5;
    tv.push_back(ex(t, 1, 1, 0, 5));
    t = mk(1, 6, 1); t.rs1 = 5; t.rs1e = 1;
    tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(1, 7, 1); t.rs1 = 6; t.rs1e = 1;
    tv.push_back(ex(t, 1, 1, 0, 6));
    t = mk(0, 0, 0); tv.push_back(ex(t, 0, 0, 1, 0));
    t = mk(1, 8, 1); t.rd = 9; t.rde = 1; t.iv = 1; t.ii = 6;
    tv.push_back(ex(t, 1, 1, 0, 7));
    t = mk(1, 9, 1); t.rs1 = 9; t.rs1e = 1; t.iv = 1; t.ii = 9;
    tv.push_back(ex(t, 1, 1, 0, 8));
    t = mk(0, 0, 0); t = ex(t, 0, 0, 1, 0);
    t.cb = 1; t.ebi = 32'h0000_0200; tv.push_back(t);
    t = mk(1, 10, 1); t.rs1e = 1; t.rde = 1; t.iv = 1; t.ii = 9;
    tv.push_back(ex(t, 1, 1, 0, 9));
    t = mk(1, 11, 1); t.rs1e = 1; t.rde = 1;
    tv.push_back(ex(t, 1, 1, 0, 10));
    t = mk(0, 0, 0); tv.push_back(ex(t, 1, 1, 0, 11));
    t = mk(1, 12, 4); tv.push_back(ex(t, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      t = mk(1, 13, 1); t.ur = 4'b1011;
      tv.push_back(ex(t, 0, 4, 1, 12));
    end
    t = mk(1, 13, 1); tv.push_back(ex(t, 1, 4, 0, 12));
    t = mk(0, 0, 0); tv.push_back(ex(t, 1, 1, 0, 13));
    t = mk(1, 14, 4'hE); tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(1, 15, 0); t.rd = 3; t.rde = 1;
    tv.push_back(ex(t, 1, 2, 0, 14));
    t = mk(1, 16, 1); t.rs1 = 3; t.rs1e = 1;
    tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(0, 0, 0); tv.push_back(ex(t, 1, 1, 0, 16));
    t = mk(1, 17, 8); t.frd = 3; t.frde = 1;
    tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(1, 18, 8); t.f3 = 3; t.f3e = 1; t.frd = 4; t.frde = 1;
    tv.push_back(ex(t, 1, 8, 0, 17));
    t = mk(0, 0, 0); tv.push_back(ex(t, 0, 0, 1, 0));
    t = mk(0, 0, 0); t.fv = 1; t.fi = 3;
    tv.push_back(ex(t, 1, 8, 0, 18));
    t = mk(1, 19, 8); t.frd = 4; t.frde = 1;
    tv.push_back(ex(t, 1, 0, 0, 0));
    t = mk(0, 0, 0); tv.push_back(ex(t, 0, 0, 1, 0));
    t = mk(1, 20, 1); t.rd = 20; t.rde = 1; t.fv = 1; t.fi = 4;
    tv.push_back(ex(t, 1, 8, 0, 19));
    t = mk(1, 21, 1); t.rd = 21; t.rde = 1;
    tv.push_back(ex(t, 1, 1, 0, 20));
    t = mk(1, 22, 2); t.rd = 22; t.rde = 1;
    tv.push_back(ex(t, 1, 1, 0, 21));
    t = mk(1, 23, 1); t.rs1 = 20; t.rs1e = 1;
    tv.push_back(ex(t, 1, 2, 0, 22));
    t = mk(0, 0, 0); tv.push_back(ex(t, 0, 0, 1, 0));
    t = mk(1, 24, 1); t.fl = 1; t.iv = 1; t.ii = 20;
    t = ex(t, 0, 0, 0, 0);
    t.cb = 1; t.ebi = 32'h0070_0000; t.ebf = 32'h10;
    tv.push_back(t);
    t = mk(1, 25, 1); t.rs1 = 21; t.rs1e = 1;
    t.f3 = 4; t.f3e = 1; t.rd = 22; t.rde = 1;
    t = ex(t, 1, 0, 0, 0); t.cb = 1;
    tv.push_back(t);
    t = mk(0, 0, 0); tv.push_back(ex(t, 1, 1, 0, 25));
    t = mk(0, 0, 0); tv.push_back(ex(t, 1, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int   sent;
    int   got;
    logic pend;
    logic acc;
    exp_t e;
    exp_t cur;

    n_cmp = 0;
    n_bad = 0;
    arst_n = 1'b0;
    drv(mk(0, 0, 0));
    #2;
    chk("rst.rdy", 32'(dec_if.ready), 32'd1);
    chk("rst.uv", 32'(uv), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.pkt", 32'(upkt == '0), 32'd1);
    #10 arst_n = 1'b1;

    build();
    for (int k = 0; k < tv.size(); k++) begin
      @(posedge clk);
      #1;
      drv(tv[k]);
      #3;
      chk($sformatf("v%0d.rdy", k),
          32'(dec_if.ready), 32'(tv[k].erdy));
      chk($sformatf("v%0d.uv", k), 32'(uv), 32'(tv[k].euv));
      chk($sformatf("v%0d.stall", k),
          32'(stall), 32'(tv[k].est));
      if (tv[k].euv != 4'd0) begin
        chk($sformatf("v%0d.tag", k),
            32'(upkt.itag), 32'(tv[k].etag));
      end
      if (tv[k].cb) begin
        chk($sformatf("v%0d.ibusy", k),
            dut.u_iscb.busy_q, tv[k].ebi);
        chk($sformatf("v%0d.fbusy", k),
            dut.u_fscb.busy_q, tv[k].ebf);
      end
    end

    @(posedge clk); #1;
    t = mk(1, 30, 1); t.rd = 5; t.rde = 1; drv(t);
    @(posedge clk); #1;
    t = mk(1, 31, 1); t.rs1 = 5; t.rs1e = 1; drv(t);
    @(posedge clk); #1;
    drv(mk(0, 0, 0));
    #2;
    chk("rstmid.stall_pre", 32'(stall), 32'd1);
    #1 arst_n = 1'b0;
    #1;
    chk("rstmid.uv", 32'(uv), 32'd0);
    chk("rstmid.stall", 32'(stall), 32'd0);
    chk("rstmid.rdy", 32'(dec_if.ready), 32'd1);
    chk("rstmid.pkt", 32'(upkt == '0), 32'd1);
    #2 arst_n = 1'b1;
    @(posedge clk); #1;
    t = mk(1, 32, 1); t.rs1 = 5; t.rs1e = 1; drv(t);
    @(posedge clk); #1;
    drv(mk(0, 0, 0));
    #3;
    chk("rstmid.uv_after", 32'(uv), 32'd1);
    chk("rstmid.tag_after", 32'(upkt.itag), 32'd32);

    sent = 0;
    got = 0;
    pend = 1'b0;
    cur = '0;
    for (int c = 0; c < 2000 && got < 40; c++) begin
      @(posedge clk); #1;
      if (!pend && sent < 40 && $urandom_range(0, 3) != 0) begin
        cur.tag = 8'(100 + sent);
        cur.dest = 4'(1 << $urandom_range(0, 3));
        exp_q.push_back(cur);
        sent++;
        pend = 1'b1;
      end
      t = mk(pend, cur.tag, cur.dest);
      t.ur = 4'($urandom_range(0, 15));
      drv(t);
      #3;
      acc = dec_if.valid & dec_if.ready;
      if (|(uv & ur)) begin
        if (exp_q.size() == 0) begin
          chk("stream.extra", 32'(upkt.itag), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stream.tag", 32'(upkt.itag), 32'(e.tag));
          chk("stream.uv", 32'(uv), 32'(e.dest));
        end
        got++;
      end
      if (acc) pend = 1'b0;
    end
    chk("stream.count", 32'(got), 32'd40);
    chk("stream.left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
